// File: rtl/pc_pkg.sv
// Shared types and default sizes for the program-counter sequencer slice.
package pc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_t;

   localparam int PC_W_DEF      = 16;
   localparam int OFF_W_DEF     = 8;
   localparam int RAS_DEPTH_DEF = 4;

endpackage : pc_pkg

// File: rtl/pc_sequencer_if.sv
// Control/address bundle between the control decoder (master) and the
// program-counter sequencer (slave).
interface pc_sequencer_if
   import pc_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int OFF_W = OFF_W_DEF
);

   logic             start;
   logic             stall;
   logic             halt_req;
   logic             branch_en;
   logic             branch_abs;
   logic [PC_W-1:0]  branch_target;
   logic [OFF_W-1:0] branch_off;
   logic             call;
   logic             ret;
   logic [PC_W-1:0]  pc;
   logic             running;
   logic             halt;
   logic             fault;

   modport master (
      output start, stall, halt_req, branch_en, branch_abs,
             branch_target, branch_off, call, ret,
      input  pc, running, halt, fault
   );

   modport slave (
      input  start, stall, halt_req, branch_en, branch_abs,
             branch_target, branch_off, call, ret,
      output pc, running, halt, fault
   );

endinterface : pc_sequencer_if

// File: rtl/pc_ras.sv
// Return-address stack: DEPTH entries of W bits, synchronous reset.
// The parent never issues push and pop together; a push while full or a
// pop while empty is ignored here and reported by the parent.
module pc_ras
   import pc_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH_DEF,
   parameter int W     = PC_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [CNT_W-1:0] count;
   logic [IDX_W-1:0] top_idx;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign top_idx = count[IDX_W-1:0] - IDX_W'(1);
   assign top     = mem[top_idx];

   // Occupancy count; reset empties the stack.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      if (reset) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         count <= count - CNT_W'(1);
      end
   end

   // Entry storage, written on accepted pushes.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; entries above
      // the count are never read, so clearing them would only cost logic.
      if (push && !full) begin
         mem[count[IDX_W-1:0]] <= push_data;
      end
   end

endmodule : pc_ras

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the instruction-fetch front end.
// Optional return-address stack enabled by defining PC_RAS_EN; without it
// call acts as a plain branch, ret is ignored and fault stays low.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              PC_W       = PC_W_DEF,
   parameter int              OFF_W      = OFF_W_DEF,
   parameter int              RAS_DEPTH  = RAS_DEPTH_DEF,
   parameter logic [PC_W-1:0] START_ADDR = '0
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);

   if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
   end
   if (OFF_W > PC_W) begin : g_bad_off
      $error("pc_sequencer: OFF_W must not exceed PC_W");
   end

   pc_state_t       state_q;
   logic [PC_W-1:0] pc_q;
   logic            running_q;
   logic            halt_q;
   logic [PC_W-1:0] pc_plus1;
   logic [PC_W-1:0] off_ext;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_next;
   logic            advance;

   // Offset is sign-extended; all sums wrap modulo 2^PC_W.
   assign pc_plus1 = pc_q + PC_W'(1);
   assign off_ext  = PC_W'(signed'(bus.branch_off));
   assign target   = bus.branch_abs ? bus.branch_target : (pc_q + off_ext);
   assign advance  = (state_q == RUN) && !bus.halt_req && !bus.stall;

`ifdef PC_RAS_EN
   logic            fault_q;
   logic            ras_push;
   logic            ras_pop;
   logic            ras_err;
   logic [PC_W-1:0] ras_top;
   logic            ras_full;
   logic            ras_empty;

   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus1),
      .top       (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   // Next PC and stack requests in RUN: ret beats branch, branch beats +1.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned and infers a latch.
      pc_next  = pc_plus1;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      ras_err  = 1'b0;
      if (bus.ret) begin
         if (ras_empty) begin
            ras_err = advance;
         end else begin
            pc_next = ras_top;
            ras_pop = advance;
         end
      end else if (bus.branch_en) begin
         pc_next = target;
         if (bus.call) begin
            ras_push = advance && !ras_full;
            ras_err  = advance && ras_full;
         end
      end
   end

   assign bus.fault = fault_q;
`else
   // Next PC in RUN without a stack: call is a plain branch, ret ignored.
   always_comb begin
      pc_next = pc_plus1;
      if (bus.branch_en) begin
         pc_next = target;
      end
   end

   assign bus.fault = 1'b0;
`endif

   // Control FSM with registered pc, running, halt and fault.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= START_ADDR;
         running_q <= 1'b0;
         halt_q    <= 1'b0;
`ifdef PC_RAS_EN
         fault_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               if (bus.halt_req) begin
                  state_q   <= HALT;
                  running_q <= 1'b0;
                  halt_q    <= 1'b1;
               end else if (advance) begin
                  pc_q <= pc_next;
`ifdef PC_RAS_EN
                  if (ras_err) begin
                     fault_q <= 1'b1;
                  end
`endif
               end
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q   <= IDLE;
               running_q <= 1'b0;
               halt_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc      = pc_q;
   assign bus.running = running_q;
   assign bus.halt    = halt_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PC_W=16, OFF_W=8,
// RAS_DEPTH=4, START_ADDR=0). Expectations follow PC_RAS_EN when defined.
module tb_pc_sequencer;
   import pc_pkg::*;

`ifdef PC_RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   pc_sequencer_if #(.PC_W(16), .OFF_W(8)) bus ();

   pc_sequencer #(
      .PC_W       (16),
      .OFF_W      (8),
      .RAS_DEPTH  (4),
      .START_ADDR (16'h0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start = 0; bus.stall = 0; bus.halt_req = 0; bus.branch_en = 0;
      bus.branch_abs = 0; bus.branch_target = '0; bus.branch_off = '0;
      bus.call = 0; bus.ret = 0;
   endtask

   task automatic reset_and_start();
      clear_inputs();
      reset = 1; tick(); reset = 0;
      bus.start = 1; tick(); bus.start = 0;
   endtask

   task automatic jump(input logic [15:0] addr);
      bus.branch_en = 1; bus.branch_abs = 1; bus.branch_target = addr;
      tick();
      bus.branch_en = 0; bus.branch_abs = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1; tick(); tick(); reset = 0;
      checks++;
      if (bus.pc !== 16'h0000 || bus.running !== 1'b0 || bus.halt !== 1'b0 || bus.fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_state pc=%h run=%b halt=%b fault=%b exp 0000/0/0/0", bus.pc, bus.running, bus.halt, bus.fault);
      end
      // Controls other than start are ignored in IDLE.
      bus.branch_en = 1; bus.branch_abs = 1; bus.branch_target = 16'h0055; bus.ret = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (bus.pc !== 16'h0000 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold cyc%0d pc=%h run=%b exp 0000/0", i, bus.pc, bus.running);
         end
      end
      clear_inputs();
   endtask

   task automatic test_start();
      logic [15:0] exp_pc;
      bus.start = 1; tick(); bus.start = 0;
      for (int i = 0; i < 4; i++) begin
         exp_pc = 16'(i);
         checks++;
         if (bus.pc !== exp_pc || bus.running !== 1'b1) begin
            errors++;
            $display("FAIL start_seq step%0d pc=%h run=%b exp %h/1", i, bus.pc, bus.running, exp_pc);
         end
         tick();
      end
   endtask

   task automatic test_relative();
      jump(16'h0010);
      checks++;
      if (bus.pc !== 16'h0010) begin
         errors++; $display("FAIL abs_jump pc=%h exp 0010", bus.pc);
      end
      bus.branch_en = 1; bus.branch_abs = 0; bus.branch_off = 8'hFC;
      tick();
      checks++;
      if (bus.pc !== 16'h000C) begin
         errors++; $display("FAIL rel_neg pc=%h exp 000c", bus.pc);
      end
      bus.branch_off = 8'h7F;
      tick();
      checks++;
      if (bus.pc !== 16'h008B) begin
         errors++; $display("FAIL rel_pos pc=%h exp 008b", bus.pc);
      end
      bus.branch_en = 0;
      jump(16'h0002);
      bus.branch_en = 1; bus.branch_off = 8'h80;
      tick();
      bus.branch_en = 0;
      checks++;
      if (bus.pc !== 16'hFF82) begin
         errors++; $display("FAIL rel_wrap pc=%h exp ff82", bus.pc);
      end
   endtask

   task automatic test_wrap();
      jump(16'hFFFF);
      tick();
      checks++;
      if (bus.pc !== 16'h0000) begin
         errors++; $display("FAIL inc_wrap pc=%h exp 0000", bus.pc);
      end
      // call without branch_en is a plain increment
      bus.call = 1; tick(); bus.call = 0;
      checks++;
      if (bus.pc !== 16'h0001) begin
         errors++; $display("FAIL call_no_branch pc=%h exp 0001", bus.pc);
      end
   endtask

   task automatic test_stall();
      jump(16'h0005);
      bus.stall = 1; bus.branch_en = 1; bus.branch_abs = 1; bus.branch_target = 16'h0300;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.pc !== 16'h0005) begin
            errors++; $display("FAIL stall_hold cyc%0d pc=%h exp 0005", i, bus.pc);
         end
      end
      bus.stall = 0; bus.branch_target = 16'h0100;
      tick();
      bus.branch_en = 0; bus.branch_abs = 0;
      checks++;
      if (bus.pc !== 16'h0100) begin
         errors++; $display("FAIL stall_release pc=%h exp 0100", bus.pc);
      end
      tick();
      checks++;
      if (bus.pc !== 16'h0101) begin
         errors++; $display("FAIL after_branch pc=%h exp 0101", bus.pc);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_pc;
      reset_and_start();
      // ret on empty stack while stalled: no fault
      bus.stall = 1; bus.ret = 1; tick(); bus.stall = 0; bus.ret = 0;
      checks++;
      if (bus.fault !== 1'b0 || bus.pc !== 16'h0000) begin
         errors++; $display("FAIL stall_ret fault=%b pc=%h exp 0/0000", bus.fault, bus.pc);
      end
      jump(16'h0020);
      bus.branch_en = 1; bus.branch_abs = 1; bus.branch_target = 16'h0200; bus.call = 1;
      tick();
      checks++;
      if (bus.pc !== 16'h0200) begin
         errors++; $display("FAIL call_target pc=%h exp 0200", bus.pc);
      end
      // ret in the very next cycle; branch_en held high must be ignored
      bus.call = 0; bus.ret = 1; bus.branch_target = 16'h0777;
      tick();
      bus.ret = 0; bus.branch_en = 0; bus.branch_abs = 0;
      exp_pc = RAS ? 16'h0021 : 16'h0777;
      checks++;
      if (bus.pc !== exp_pc || bus.fault !== 1'b0) begin
         errors++; $display("FAIL call_ret pc=%h fault=%b exp %h/0", bus.pc, bus.fault, exp_pc);
      end
   endtask

   task automatic test_ras_nesting();
      logic [15:0] exp_pc;
      logic [15:0] ret_tab [5];
      ret_tab = '{16'h4001, 16'h3001, 16'h2001, 16'h1001, 16'h1002};
      reset_and_start();
      jump(16'h1000);
      for (int k = 1; k <= 5; k++) begin
         bus.branch_en = 1; bus.branch_abs = 1; bus.call = 1;
         bus.branch_target = 16'((k + 1) * 16'h1000);
         tick();
         exp_pc = 16'((k + 1) * 16'h1000);
         checks++;
         if (bus.pc !== exp_pc || bus.fault !== (RAS && k == 5)) begin
            errors++;
            $display("FAIL nest_call%0d pc=%h fault=%b exp %h/%b", k, bus.pc, bus.fault, exp_pc, RAS && k == 5);
         end
      end
      clear_inputs();
      exp_pc = 16'h6000;
      for (int k = 0; k < 5; k++) begin
         bus.ret = 1; tick();
         exp_pc = RAS ? ret_tab[k] : exp_pc + 16'h0001;
         checks++;
         if (bus.pc !== exp_pc || bus.fault !== RAS) begin
            errors++;
            $display("FAIL nest_ret%0d pc=%h fault=%b exp %h/%b", k, bus.pc, bus.fault, exp_pc, RAS);
         end
      end
      bus.ret = 0;
      // underflow from a fresh reset
      reset_and_start();
      bus.ret = 1; tick(); bus.ret = 0;
      checks++;
      if (bus.pc !== 16'h0001 || bus.fault !== RAS) begin
         errors++; $display("FAIL underflow pc=%h fault=%b exp 0001/%b", bus.pc, bus.fault, RAS);
      end
   endtask

   task automatic test_halt();
      // fault from the preceding underflow must survive until reset
      jump(16'h0042);
      bus.halt_req = 1; bus.branch_en = 1; bus.branch_abs = 1; bus.branch_target = 16'h0300;
      tick();
      bus.halt_req = 0;
      checks++;
      if (bus.halt !== 1'b1 || bus.running !== 1'b0 || bus.pc !== 16'h0042) begin
         errors++; $display("FAIL halt_enter halt=%b run=%b pc=%h exp 1/0/0042", bus.halt, bus.running, bus.pc);
      end
      for (int i = 0; i < 3; i++) begin
         bus.start = 1; tick(); bus.start = 0; tick();
         checks++;
         if (bus.halt !== 1'b1 || bus.running !== 1'b0 || bus.pc !== 16'h0042 || bus.fault !== RAS) begin
            errors++;
            $display("FAIL halt_sticky%0d halt=%b run=%b pc=%h fault=%b exp 1/0/0042/%b", i, bus.halt, bus.running, bus.pc, bus.fault, RAS);
         end
      end
      clear_inputs();
      reset = 1; tick(); reset = 0;
      checks++;
      if (bus.pc !== 16'h0000 || bus.halt !== 1'b0 || bus.fault !== 1'b0 || bus.running !== 1'b0) begin
         errors++;
         $display("FAIL halt_reset pc=%h halt=%b fault=%b run=%b exp 0000/0/0/0", bus.pc, bus.halt, bus.fault, bus.running);
      end
      bus.start = 1; tick(); bus.start = 0; tick();
      checks++;
      if (bus.pc !== 16'h0001 || bus.running !== 1'b1) begin
         errors++; $display("FAIL restart pc=%h run=%b exp 0001/1", bus.pc, bus.running);
      end
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_start();
      test_relative();
      test_wrap();
      test_stall();
      test_back_to_back();
      test_ras_nesting();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the instruction-fetch front end. It generates the instruction address for the instruction ROM and supports start, stall and halt control. Branches can be absolute or PC-relative with a signed offset. An optional return-address stack handles call/return. It replaces the fixed 16-bit jump-only counter and sits between the control decoder and the instruction ROM address port.

## Interface
Parameters:
- PC_W, 16, PC / address width in bits
- OFF_W, 8, width of signed relative branch offset
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)
- START_ADDR, 0, PC value loaded on reset and held in IDLE

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  leave IDLE and begin fetching
- stall  in  1  hold PC this cycle (RUN only)
- halt_req  in  1  stop fetching; enter HALT
- branch_en  in  1  redirect PC this cycle
- branch_abs  in  1  1: target = branch_target; 0: PC + sext(branch_off)
- branch_target  in  PC_W  absolute target
- branch_off  in  OFF_W  signed two's-complement offset
- call  in  1  with branch_en: push PC+1, then branch
- ret  in  1  pop return address into PC
- pc  out  PC_W  current fetch address (registered)
- running  out  1  state == RUN
- halt  out  1  state == HALT (sticky)
- fault  out  1  sticky RAS overflow/underflow flag

## Operation
- States: IDLE, RUN, HALT.
  - IDLE→RUN when start=1.
  - RUN→HALT when halt_req=1.
  - HALT holds until reset. start is ignored in HALT.
- Reset (any state, any cycle): state=IDLE, pc=START_ADDR, running=0, halt=0, fault=0, RAS emptied. This is also the required behaviour on reset mid-branch or mid-call.
- IDLE: pc held at START_ADDR. All control inputs except start are ignored.
- First RUN cycle presents START_ADDR. Updates begin on the following edge.
- RUN next-PC priority, highest first:
  1. halt_req: pc held, enter HALT.
  2. stall: pc held, no RAS change.
  3. ret: pc = popped entry. branch_en and call in the same cycle are ignored.
  4. branch_en: pc = target. If call=1, PC+1 is pushed first.
  5. Otherwise pc = pc+1.
- call without branch_en is ignored.
- Arithmetic: all of pc+1, pc+sext(branch_off) and the push value are modulo 2^PC_W. Wrap from all-ones to 0 is silent and legal. Offset is sign-extended from OFF_W to PC_W.
- RAS overflow (call when full): push dropped, branch still taken, fault=1.
- RAS underflow (ret when empty): pc = pc+1, fault=1.
- fault clears only on reset.

## Timing
- All outputs registered. A control input sampled at edge N is reflected on pc at edge N (visible in cycle N+1). Latency is 1 cycle.
- start sampled in IDLE → running=1 the next cycle, pc=START_ADDR.
- halt_req sampled → halt=1 and running=0 the next cycle. pc freezes at its value from the halt_req cycle.
- Call followed immediately by ret in the next RUN cycle returns to the call-site PC+1. No bubble.
- Stalled cycles never modify RAS or fault.

## Configuration
- PC_RAS_EN defined: RAS instantiated. call/ret/fault behave as above.
- PC_RAS_EN undefined: no RAS storage. call is treated as a plain branch. ret is ignored (pc=pc+1). fault is tied to 0.

## Structure
- Package pc_pkg holds:
  - state enum pc_state_t {IDLE, RUN, HALT}
  - default parameter constants (PC_W_DEF=16, OFF_W_DEF=8, RAS_DEPTH_DEF=4)
- Sub-module pc_ras: RAS_DEPTH×PC_W stack.
  - Inputs: push, pop, push_data.
  - Outputs: top, full, empty.
  - Synchronous reset. Simultaneous push and pop never issued by the parent.

## Test plan
- Reset, hold start=0 for 5 cycles → pc=0, running=0. Pulse start → running=1, pc sequence 0,1,2,3.
- PC_W=16: pc=0x0010, branch_en=1, branch_abs=0, branch_off=0xFC (−4) → pc=0x000C. pc=0xFFFF with no branch → pc=0x0000.
- pc=0x0005, stall=1 for 3 cycles then branch_abs=1, target=0x0100 → pc holds 0x0005 ×3, then 0x0100.
- PC_RAS_EN: call at pc=0x0020 to 0x0200, then ret → pc 0x0200 then 0x0021. Five nested calls with RAS_DEPTH=4 → fault=1 on the fifth. Ret with empty RAS → fault=1 and pc=pc+1.
- halt_req at pc=0x0042 while branch_en=1 → halt=1, pc stays 0x0042. start pulses have no effect. reset → pc=START_ADDR, halt=0, fault=0.
